// File: rtl/regfile_pkg.sv
// Shared constants and clear-sequencer state encoding for the register file.
package regfile_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_CLEAR = 1'b1;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_CLEAR = ST_CLEAR
    } clr_state_e;

    // Defaults shared with the datapath decode stage.
    localparam int RF_WIDTH    = 64;
    localparam int RF_DEPTH    = 32;
    localparam int RF_ZERO_REG = 31;

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: after a clrStart pulse, steps an index over every register,
// asserting clrWe for exactly DEPTH cycles.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int DEPTH  = RF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clrStart,
    output logic              clrBusy,
    output logic [ADDR_W-1:0] clrIdx,
    output logic              clrWe
);

    clr_state_e        state_q;
    logic              busy_q;
    logic [ADDR_W-1:0] idx_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (clrStart) begin
                        state_q <= S_CLEAR;
                        busy_q  <= 1'b1;
                        idx_q   <= '0;
                    end
                end
                S_CLEAR: begin
                    // clrStart is deliberately not looked at here: no restart, no extension.
                    idx_q <= idx_q + ADDR_W'(1);
                    if (idx_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign clrWe   = (state_q == S_CLEAR);
    assign clrBusy = busy_q;
    assign clrIdx  = idx_q;

endmodule

// File: rtl/regfile_param.sv
// WIDTH x DEPTH register file, one write port, two combinational read ports,
// optional zero register and sequential clear. Macro REGFILE_BYPASS_EN adds write-to-read forwarding.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int DEPTH    = RF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ZERO_EN  = 1,
    parameter int ZERO_REG = RF_ZERO_REG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [WIDTH-1:0]  wrData,
    input  logic [ADDR_W-1:0] rdAddrA,
    output logic [WIDTH-1:0]  rdDataA,
    input  logic [ADDR_W-1:0] rdAddrB,
    output logic [WIDTH-1:0]  rdDataB,
    input  logic              clrStart,
    output logic              clrBusy
);

    logic [WIDTH-1:0]  regs_q [DEPTH];
    logic [WIDTH-1:0]  regs_d [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_idx;
    logic              wr_zero;
    logic              wr_en;

    regfile_clr_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk      (clk),
        .reset    (reset),
        .clrStart (clrStart),
        .clrBusy  (clrBusy),
        .clrIdx   (clr_idx),
        .clrWe    (clr_we)
    );

    assign wr_zero = (ZERO_EN != 0) && (wrAddr == ADDR_W'(ZERO_REG));
    // Writes only land while the sequencer is idle; clr_we is high exactly while clearing.
    assign wr_en   = write && !clr_we && !wr_zero;

    always_comb begin
        regs_d = regs_q;
        if (clr_we) begin
            regs_d[clr_idx] = '0;
        end else if (wr_en) begin
            regs_d[wrAddr] = wrData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rdDataA = regs_q[rdAddrA];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (wrAddr == rdAddrA)) begin
            rdDataA = wrData;
        end
`endif
        if ((ZERO_EN != 0) && (rdAddrA == ADDR_W'(ZERO_REG))) begin
            rdDataA = '0;
        end
    end

    always_comb begin
        rdDataB = regs_q[rdAddrB];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (wrAddr == rdAddrB)) begin
            rdDataB = wrData;
        end
`endif
        if ((ZERO_EN != 0) && (rdAddrB == ADDR_W'(ZERO_REG))) begin
            rdDataB = '0;
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: one instance with the zero register, one without,
// both driven by the same stimulus and compared against an array-based reference model.
module tb_regfile_param;

    localparam int W  = 64;
    localparam int D  = 32;
    localparam int AW = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          write;
    logic          clrStart;
    logic [AW-1:0] wrAddr, rdAddrA, rdAddrB;
    logic [W-1:0]  wrData;
    logic [W-1:0]  rdA_z, rdB_z, rdA_n, rdB_n;
    logic          busy_z, busy_n;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mem [D];
    bit           m_busy;
    int           m_idx;

    always #5 clk = ~clk;

    regfile_param dut (
        .clk(clk), .reset(reset), .write(write), .wrAddr(wrAddr), .wrData(wrData),
        .rdAddrA(rdAddrA), .rdDataA(rdA_z), .rdAddrB(rdAddrB), .rdDataB(rdB_z),
        .clrStart(clrStart), .clrBusy(busy_z)
    );

    regfile_param #(.ZERO_EN(0)) dut_nz (
        .clk(clk), .reset(reset), .write(write), .wrAddr(wrAddr), .wrData(wrData),
        .rdAddrA(rdAddrA), .rdDataA(rdA_n), .rdAddrB(rdAddrB), .rdDataB(rdB_n),
        .clrStart(clrStart), .clrBusy(busy_n)
    );

    // Expected read value for the current inputs; zen selects the zero-register instance.
    function automatic logic [W-1:0] exp_rd(input logic [AW-1:0] a, input bit zen);
        if (zen && a == 31) return '0;
        if (BYP && write && !m_busy && wrAddr == a) return wrData;
        return mem[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < D; i++) mem[i] = '0;
        m_busy = 1'b0;
        m_idx  = 0;
    endtask

    // One rising edge: advance the model with the inputs the DUT just sampled.
    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            if (m_busy) begin
                mem[m_idx] = '0;
                m_idx++;
                if (m_idx == D) begin
                    m_busy = 1'b0;
                    m_idx  = 0;
                end
            end else begin
                if (write) mem[wrAddr] = wrData;
                if (clrStart) begin
                    m_busy = 1'b1;
                    m_idx  = 0;
                end
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        write = 0; clrStart = 0; wrAddr = '0; wrData = '0; rdAddrA = '0; rdAddrB = '0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < D; i++) begin
            write = 1; wrAddr = AW'(i); wrData = {$urandom, $urandom} | 64'h1;
            tick();
        end
        write = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        idle_inputs();
        model_reset();
        #12;
        checks++;
        if (busy_z !== 1'b0 || busy_n !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b/%b expected 0", busy_z, busy_n);
        end
        for (int i = 0; i < D; i++) begin
            rdAddrA = AW'(i); rdAddrB = AW'(D - 1 - i);
            #1;
            checks++;
            if (rdA_z !== '0 || rdB_z !== '0 || rdA_n !== '0 || rdB_n !== '0) begin
                errors++;
                $display("FAIL reset_read[%0d]: got %h %h %h %h expected 0", i, rdA_z, rdB_z, rdA_n, rdB_n);
            end
        end
        reset = 0;
        @(negedge clk);
    endtask

    task automatic test_sweep();
        for (int a = 0; a < D; a++) begin
            write = 1; wrAddr = AW'(a); wrData = {$urandom, $urandom};
            rdAddrA = AW'(a - 1); rdAddrB = AW'(a - 2);
            #1;
            checks++;
            if (rdA_z !== exp_rd(rdAddrA, 1) || rdB_z !== exp_rd(rdAddrB, 1)) begin
                errors++;
                $display("FAIL sweep_z[%0d]: got %h %h expected %h %h", a, rdA_z, rdB_z,
                         exp_rd(rdAddrA, 1), exp_rd(rdAddrB, 1));
            end
            checks++;
            if (rdA_n !== exp_rd(rdAddrA, 0)) begin
                errors++;
                $display("FAIL sweep_nz[%0d]: got %h expected %h", a, rdA_n, exp_rd(rdAddrA, 0));
            end
            tick();
        end
        write = 0; rdAddrA = 5'd31; rdAddrB = 5'd30;
        #1;
        checks++;
        if (rdA_z !== '0) begin
            errors++; $display("FAIL sweep_r31_zero: got %h expected 0", rdA_z);
        end
        checks++;
        if (rdA_n !== mem[31]) begin
            errors++; $display("FAIL sweep_r31_nz: got %h expected %h", rdA_n, mem[31]);
        end
    endtask

    task automatic test_reset_loaded();
        #2;
        reset = 1;
        #1;
        checks++;
        if (busy_z !== 1'b0 || rdA_n !== '0 || rdB_n !== '0) begin
            errors++;
            $display("FAIL reset_async_now: got busy %b data %h %h expected 0", busy_z, rdA_n, rdB_n);
        end
        model_reset();
        for (int i = 0; i < D; i++) begin
            rdAddrA = AW'(i); rdAddrB = AW'(i);
            #1;
            checks++;
            if (rdA_z !== '0 || rdB_n !== '0) begin
                errors++; $display("FAIL reset_async_r%0d: got %h %h expected 0", i, rdA_z, rdB_n);
            end
        end
        reset = 0;
        @(negedge clk);
    endtask

    task automatic test_zero_off();
        write = 1; wrAddr = 5'd31; wrData = 64'hDEAD_BEEF_0123_4567;
        tick();
        write = 0; rdAddrA = 5'd31; rdAddrB = 5'd31;
        #1;
        checks++;
        if (rdA_n !== 64'hDEAD_BEEF_0123_4567 || rdB_n !== 64'hDEAD_BEEF_0123_4567) begin
            errors++; $display("FAIL zero_off_r31: got %h %h expected deadbeef01234567", rdA_n, rdB_n);
        end
        checks++;
        if (rdA_z !== '0) begin
            errors++; $display("FAIL zero_on_r31: got %h expected 0", rdA_z);
        end
    endtask

    task automatic test_clear();
        int busy_cnt;
        busy_cnt = 0;
        fill_random();
        clrStart = 1;
        tick();
        clrStart = 0;
        for (int n = 1; n <= D; n++) begin
            write = (n == 5); wrAddr = '0; wrData = '1; clrStart = (n == 10);
            rdAddrA = AW'(n - 1); rdAddrB = AW'(n);
            #1;
            if (busy_z === 1'b1) busy_cnt++;
            checks++;
            if (busy_z !== 1'b1) begin
                errors++; $display("FAIL clear_busy_k+%0d: got %b expected 1", n, busy_z);
            end
            checks++;
            if (rdA_n !== exp_rd(rdAddrA, 0)) begin
                errors++; $display("FAIL clear_pre_r%0d: got %h expected %h", n - 1, rdA_n, exp_rd(rdAddrA, 0));
            end
            tick();
            checks++;
            if (rdA_n !== '0 || rdA_z !== '0) begin
                errors++; $display("FAIL clear_post_r%0d: got %h %h expected 0", n - 1, rdA_n, rdA_z);
            end
        end
        write = 0; clrStart = 0; rdAddrA = '0;
        #1;
        checks++;
        if (busy_z !== 1'b0 || busy_n !== 1'b0) begin
            errors++; $display("FAIL clear_done_busy: got %b/%b expected 0", busy_z, busy_n);
        end
        checks++;
        if (busy_cnt != D) begin
            errors++; $display("FAIL clear_busy_len: got %0d expected %0d", busy_cnt, D);
        end
        checks++;
        if (rdA_n !== '0) begin
            errors++; $display("FAIL clear_dropped_write: got %h expected 0", rdA_n);
        end
    endtask

    task automatic test_bypass();
        logic [W-1:0] v, ex;
        v = {$urandom, $urandom} | 64'h2;
        write = 1; wrAddr = 5'd5; wrData = v;
        tick();
        wrData = 64'h1; rdAddrA = 5'd5; rdAddrB = 5'd5;
        #1;
        ex = BYP ? 64'h1 : v;
        checks++;
        if (rdA_z !== ex || rdB_n !== ex) begin
            errors++; $display("FAIL bypass_r5: got %h %h expected %h", rdA_z, rdB_n, ex);
        end
        tick();
        write = 0;
        #1;
        checks++;
        if (rdA_z !== 64'h1) begin
            errors++; $display("FAIL bypass_after_edge: got %h expected 1", rdA_z);
        end
        write = 1; wrAddr = 5'd31; wrData = '1; rdAddrA = 5'd31; rdAddrB = 5'd31;
        #1;
        checks++;
        if (rdA_z !== '0 || rdB_z !== '0) begin
            errors++; $display("FAIL bypass_zero_reg: got %h %h expected 0", rdA_z, rdB_z);
        end
        checks++;
        if (rdA_n !== exp_rd(5'd31, 0)) begin
            errors++; $display("FAIL bypass_r31_nz: got %h expected %h", rdA_n, exp_rd(5'd31, 0));
        end
        tick();
        write = 0;
    endtask

    task automatic test_reset_mid_clear();
        logic [W-1:0] v7;
        fill_random();
        clrStart = 1;
        tick();
        clrStart = 0;
        repeat (6) tick();
        #2;
        reset = 1;
        #1;
        checks++;
        if (busy_z !== 1'b0 || busy_n !== 1'b0) begin
            errors++; $display("FAIL midclr_reset_busy: got %b/%b expected 0", busy_z, busy_n);
        end
        reset = 0;
        model_reset();
        #1;
        v7 = {$urandom, $urandom} | 64'h1;
        write = 1; wrAddr = 5'd0; wrData = 64'h55;
        tick();
        wrAddr = 5'd7; wrData = v7;
        tick();
        write = 0; clrStart = 1;
        tick();
        clrStart = 0;
        checks++;
        if (busy_z !== 1'b1) begin
            errors++; $display("FAIL restart_busy: got %b expected 1", busy_z);
        end
        tick();
        rdAddrA = 5'd0; rdAddrB = 5'd7;
        #1;
        checks++;
        if (rdA_z !== '0 || rdB_z !== v7) begin
            errors++; $display("FAIL restart_index0: got %h %h expected 0 %h", rdA_z, rdB_z, v7);
        end
        repeat (D - 1) tick();
        checks++;
        if (busy_z !== 1'b0) begin
            errors++; $display("FAIL restart_done: got %b expected 0", busy_z);
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 300; c++) begin
            write    = 1'($urandom_range(0, 1));
            wrAddr   = AW'($urandom);
            wrData   = {$urandom, $urandom};
            rdAddrA  = ($urandom_range(0, 3) == 0) ? wrAddr : AW'($urandom);
            rdAddrB  = AW'($urandom);
            clrStart = ($urandom_range(0, 49) == 0);
            #1;
            checks++;
            if (busy_z !== m_busy || busy_n !== m_busy) begin
                errors++; $display("FAIL rand_busy[%0d]: got %b/%b expected %b", c, busy_z, busy_n, m_busy);
            end
            checks++;
            if (rdA_z !== exp_rd(rdAddrA, 1) || rdB_z !== exp_rd(rdAddrB, 1)) begin
                errors++;
                $display("FAIL rand_z[%0d]: got %h %h expected %h %h", c, rdA_z, rdB_z,
                         exp_rd(rdAddrA, 1), exp_rd(rdAddrB, 1));
            end
            checks++;
            if (rdA_n !== exp_rd(rdAddrA, 0) || rdB_n !== exp_rd(rdAddrB, 0)) begin
                errors++;
                $display("FAIL rand_nz[%0d]: got %h %h expected %h %h", c, rdA_n, rdB_n,
                         exp_rd(rdAddrA, 0), exp_rd(rdAddrB, 0));
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_reset_loaded();
        test_zero_off();
        test_clear();
        test_bypass();
        test_reset_mid_clear();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
